// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/shift/rotate/load/clear per cycle, plus a
// counted burst mode that repeats one shift/rotate a requested number of times.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  input  logic [WIDTH-1:0] pin,
  input  logic             start,
  input  logic [CW-1:0]    cnt,
  output logic [WIDTH-1:0] pout,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_SHR   = 3'b001,
    M_SHL   = 3'b010,
    M_ROR   = 3'b011,
    M_ROL   = 3'b100,
    M_LOAD  = 3'b101,
    M_CLEAR = 3'b110,
    M_RSVD  = 3'b111
  } mode_e;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic             s_msb,
    input logic             s_lsb,
    input logic [WIDTH-1:0] par
  );
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    case (op)
      M_SHR:   nxt = {s_msb, cur[WIDTH-1:1]};
      M_SHL:   nxt = {cur[WIDTH-2:0], s_lsb};
      M_ROR:   nxt = {cur[0], cur[WIDTH-1:1]};
      M_ROL:   nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_LOAD:  nxt = par;
      M_CLEAR: nxt = '0;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // Only the four shift/rotate modes can be repeated as a burst.
  function automatic logic is_burst_op(input logic [2:0] op);
    return (op == M_SHR) || (op == M_SHL) || (op == M_ROR) || (op == M_ROL);
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (start && is_burst_op(mode)) begin
            if (cnt != '0) begin
              op_d    = mode;
              cnt_d   = cnt;
              state_d = S_BURST;
              busy_d  = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end else begin
            q_d = apply_op(mode, q_q, sin_msb, sin_lsb, pin);
          end
        end
        S_BURST: begin
          q_d   = apply_op(op_q, q_q, sin_msb, sin_lsb, pin);
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      op_q    <= M_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pout   = q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8): expected pout/busy/done
// are queued when each cycle's stimulus is driven and compared after the edge.
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [2:0]       mode;
  logic             sin_msb;
  logic             sin_lsb;
  logic [WIDTH-1:0] pin;
  logic             start;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pout;
  logic             sout_r;
  logic             sout_l;
  logic             busy;
  logic             done;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] pout;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .sin_msb (sin_msb),
    .sin_lsb (sin_lsb),
    .pin     (pin),
    .start   (start),
    .cnt     (cnt),
    .pout    (pout),
    .sout_r  (sout_r),
    .sout_l  (sout_l),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [2:0] m,
                       input logic st, input logic [CW-1:0] c,
                       input logic [WIDTH-1:0] p, input logic smsb, input logic slsb);
    rst     = r;
    en      = e;
    mode    = m;
    start   = st;
    cnt     = c;
    pin     = p;
    sin_msb = smsb;
    sin_lsb = slsb;
  endtask

  // Queue the expectation for the current stimulus, clock once, then score.
  task automatic cycle(input string tag, input logic [WIDTH-1:0] ep,
                       input logic eb, input logic ed);
    exp_t e;
    sb.push_back('{tag, ep, eb, ed});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_pout"}, pout, e.pout);
      check({e.tag, "_busy"}, busy, e.busy);
      check({e.tag, "_done"}, done, e.done);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] rv;
    logic [3:0]       smsb_seq;
    logic [3:0]       sr_seq;
    logic [WIDTH-1:0] shr_exp [4];

    drive(1, 1, 3'b101, 0, 0, 8'hFF, 0, 0);
    @(negedge clk);

    // Reset dominates a concurrent parallel load.
    cycle("rst0", 8'h00, 0, 0);
    cycle("rst1", 8'h00, 0, 0);

    // Load then shift right with serial input 1,1,0,1.
    drive(0, 1, 3'b101, 0, 0, 8'hA5, 0, 0);
    cycle("load_a5", 8'hA5, 0, 0);
    check("sout_l_a5", sout_l, 1'b1);
    smsb_seq   = 4'b1011;  // bit i is the serial bit for shift i
    sr_seq     = 4'b0101;
    shr_exp[0] = 8'hD2; shr_exp[1] = 8'hE9; shr_exp[2] = 8'h74; shr_exp[3] = 8'hBA;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("shr_sout_r%0d", i), sout_r, sr_seq[i]);
      drive(0, 1, 3'b001, 0, 0, 8'h00, smsb_seq[i], 0);
      cycle($sformatf("shr%0d", i), shr_exp[i], 0, 0);
    end

    // Burst rotate left by 3 from 81; mode/start/pin changes must be ignored.
    drive(0, 1, 3'b101, 0, 0, 8'h81, 0, 0);
    cycle("load_81", 8'h81, 0, 0);
    drive(0, 1, 3'b100, 1, 3, 8'h00, 0, 0);
    cycle("rol_start", 8'h81, 1, 0);
    drive(0, 1, 3'b110, 1, 7, 8'h55, 1, 1);
    cycle("rol_op1", 8'h03, 1, 0);
    cycle("rol_op2", 8'h06, 1, 0);
    cycle("rol_op3", 8'h0C, 0, 1);
    drive(0, 1, 3'b000, 0, 0, 8'h00, 0, 0);
    cycle("rol_after", 8'h0C, 0, 0);

    // Burst shift left by 4 with a two-cycle enable pause after op 2.
    drive(0, 1, 3'b110, 0, 0, 8'h00, 0, 0);
    cycle("clr", 8'h00, 0, 0);
    drive(0, 1, 3'b010, 1, 4, 8'h00, 0, 1);
    cycle("shl_start", 8'h00, 1, 0);
    cycle("shl_op1", 8'h01, 1, 0);
    cycle("shl_op2", 8'h03, 1, 0);
    drive(0, 0, 3'b010, 1, 4, 8'h00, 0, 1);
    cycle("shl_pause1", 8'h03, 1, 0);
    cycle("shl_pause2", 8'h03, 1, 0);
    drive(0, 1, 3'b000, 0, 0, 8'h00, 0, 1);
    cycle("shl_op3", 8'h07, 1, 0);
    cycle("shl_op4", 8'h0F, 0, 1);
    cycle("shl_after", 8'h0F, 0, 0);

    // Reset in the middle of a 5-op burst, then a fresh burst.
    drive(0, 1, 3'b110, 0, 0, 8'h00, 0, 0);
    cycle("clr2", 8'h00, 0, 0);
    drive(0, 1, 3'b010, 1, 5, 8'h00, 0, 1);
    cycle("mid_start", 8'h00, 1, 0);
    drive(0, 1, 3'b000, 0, 0, 8'h00, 0, 1);
    cycle("mid_op1", 8'h01, 1, 0);
    cycle("mid_op2", 8'h03, 1, 0);
    drive(1, 1, 3'b000, 0, 0, 8'h00, 0, 1);
    cycle("mid_rst", 8'h00, 0, 0);
    drive(0, 1, 3'b000, 0, 0, 8'h00, 0, 1);
    cycle("mid_post", 8'h00, 0, 0);
    drive(0, 1, 3'b101, 0, 0, 8'h01, 0, 0);
    cycle("load_01", 8'h01, 0, 0);
    drive(0, 1, 3'b011, 1, 2, 8'h00, 0, 0);
    cycle("ror_start", 8'h01, 1, 0);
    drive(0, 1, 3'b000, 0, 0, 8'h00, 0, 0);
    cycle("ror_op1", 8'h80, 1, 0);
    cycle("ror_op2", 8'h40, 0, 1);

    // Degenerate requests: zero count, then a non-burst mode with start.
    drive(0, 1, 3'b001, 1, 0, 8'h00, 1, 0);
    cycle("cnt0", 8'h40, 0, 1);
    drive(0, 1, 3'b000, 0, 0, 8'h00, 0, 0);
    cycle("cnt0_after", 8'h40, 0, 0);
    drive(0, 1, 3'b101, 1, 2, 8'h3C, 0, 0);
    cycle("start_load", 8'h3C, 0, 0);
    drive(0, 1, 3'b000, 0, 0, 8'h00, 0, 0);
    cycle("start_load_after", 8'h3C, 0, 0);

    // Count beyond WIDTH: 9 rotate-lefts from 3C.
    drive(0, 1, 3'b100, 1, 9, 8'h00, 0, 0);
    cycle("rol9_start", 8'h3C, 1, 0);
    drive(0, 1, 3'b000, 0, 0, 8'h00, 0, 0);
    rv = 8'h3C;
    for (int i = 1; i <= 9; i++) begin
      rv = {rv[WIDTH-2:0], rv[WIDTH-1]};
      cycle($sformatf("rol9_op%0d", i), rv, (i < 9), (i == 9));
    end

    // Idle single ops: rotate right, reserved hold, enable-low freeze.
    drive(0, 1, 3'b011, 0, 0, 8'h00, 0, 0);
    cycle("idle_ror", 8'h3C, 0, 0);
    drive(0, 1, 3'b111, 0, 0, 8'hFF, 1, 1);
    cycle("idle_rsvd", 8'h3C, 0, 0);
    drive(0, 0, 3'b110, 1, 3, 8'hFF, 1, 1);
    cycle("idle_en0", 8'h3C, 0, 0);
    drive(0, 1, 3'b010, 0, 0, 8'h00, 0, 1);
    cycle("idle_shl", 8'h79, 0, 0);

    if (sb.size() != 0) check("sb_leftover", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, register width in bits (legal range 2..32).
REQ-002 SHALL provide derived parameter CW = $clog2(WIDTH+1), the width of the burst count.
REQ-003 SHALL provide port clk  input  1  rising-edge clock; the only clock.
REQ-004 SHALL provide port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL provide port en  input  1  clock enable; low freezes all state except reset.
REQ-006 SHALL provide port mode  input  3  operation select, encoding per REQ-014.
REQ-007 SHALL provide port sin_msb  input  1  serial bit entering at the MSB on shift-right.
REQ-008 SHALL provide port sin_lsb  input  1  serial bit entering at the LSB on shift-left.
REQ-009 SHALL provide port pin  input  WIDTH  parallel load data.
REQ-010 SHALL provide port start  input  1  burst request, sampled with mode and cnt.
REQ-011 SHALL provide port cnt  input  CW  number of burst operations.
REQ-012 SHALL provide port pout  output  WIDTH  register contents q.
REQ-013 SHALL provide ports sout_r = q[0] and sout_l = q[WIDTH-1], outputs, 1 bit each, combinational from q.

Function
REQ-014 SHALL decode mode as: 000 hold; 001 shift right, q={sin_msb,q[W-1:1]}; 010 shift left, q={q[W-2:0],sin_lsb}; 011 rotate right; 100 rotate left; 101 parallel load q=pin; 110 clear q=0; 111 hold (reserved).
REQ-015 SHALL, when idle with en=1 and start=0, apply one mode operation on each rising edge.
REQ-016 SHALL use two states, IDLE and BURST; the state advances only when en=1, except on reset.
REQ-017 SHALL, in IDLE on an edge with en=1, start=1, mode in 001..100 and cnt>0, latch mode and cnt, perform no operation on q at that edge, enter BURST and set busy=1.
REQ-018 SHALL, in BURST, apply the latched operation once per enabled edge, decrement the remaining count, and ignore mode, start, cnt and pin.
REQ-019 SHALL, on the enabled edge that performs the last burst operation, return to IDLE, clear busy and set done=1 for exactly one cycle.
REQ-020 SHALL, in IDLE with start=1 and cnt=0 and a shift/rotate mode, leave q unchanged, keep busy=0 and pulse done for one cycle.
REQ-021 SHALL, in IDLE with start=1 and mode not in 001..100, ignore start and execute mode as in REQ-015.
REQ-022 SHALL, when en=0 during BURST, hold q, the count, busy=1 and done=0; the burst resumes when en returns high.
REQ-023 SHALL accept cnt>WIDTH and execute exactly cnt operations (rotates wrap; shifts flush fully with serial input).
REQ-024 SHALL provide output busy (1 bit) and output done (1 bit, single-cycle pulse), both registered.

Reset
REQ-025 SHALL, on any rising edge with rst=1, force q=0, state IDLE, busy=0, done=0 and remaining count 0, regardless of en, start or an in-progress burst.
REQ-026 SHALL give rst priority over burst operation, and burst operation priority over the mode operation.

Verification (WIDTH=8)
REQ-027 Reset: assert rst 2 cycles with en=1, mode=101, pin=FF -> pout=00, busy=0, done=0.
REQ-028 Load then shift right: load A5, then mode=001 for 4 cycles with sin_msb=1,1,0,1 -> pout D2,E9,74,BA; sout_r before each edge 1,0,1,0.
REQ-029 Burst rotate left: pout=81, start with mode=100 and cnt=3 -> busy high for 3 cycles, pout 03,06,0C, done pulses once on the last edge, final pout=0C.
REQ-030 Burst pause: burst shift-left, cnt=4, sin_lsb=1 from 00, en low for 2 cycles after the 2nd operation -> pout holds 03 with busy=1 during the pause, finishes at 0F, with exactly one done pulse.
REQ-031 Reset mid-burst: rst after the 2nd of 5 operations -> next cycle pout=00, busy=0, no done pulse; a new burst then starts normally.
REQ-032 Degenerate requests: start with cnt=0 and mode=001 -> pout unchanged, busy=0, done pulses once; start with mode=101 -> parallel load executes, no busy, no done.
